mem_access_stage: RTL and testbench

- Fourth pipeline stage, between the execute stage and write-back.
- Receives execute results plus the synchronous data-RAM read word, which is valid exactly one cycle after execute drives the address.
- Performs load byte/half extraction with sign or zero extension and selects the register-file write data.
- Holds the RAM word in a capture register so the result survives back-pressure from write-back, then forwards the result to write-back and to the bypass network.

---
 rtl/mem_access_stage_pkg.sv | 51 +++++
 rtl/mem_access_stage_load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 100 ++++++++++
 tb/tb_mem_access_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the execute / memory / write-back pipeline boundary:
// bus widths, bus payload layouts, load_type and rf_wdata_sel encodings.
package mem_access_stage_pkg;

  localparam int unsigned EXE_TO_MEM_BUS_WD = 76;
  localparam int unsigned MEM_TO_WB_BUS_WD  = 70;
  localparam int unsigned MEM_TO_BY_BUS_WD  = 39;
  localparam int unsigned DATA_WD           = 32;
  localparam int unsigned RF_ADDR_WD        = 5;

  // load_type encodings (101..111 behave as LT_W)
  localparam logic [2:0] LT_W  = 3'b000;
  localparam logic [2:0] LT_B  = 3'b001;
  localparam logic [2:0] LT_BU = 3'b010;
  localparam logic [2:0] LT_H  = 3'b011;
  localparam logic [2:0] LT_HU = 3'b100;

  // rf_wdata_sel encodings
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LINK = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Execute -> memory payload; field order fixes the bit offsets (MSB first).
  typedef struct packed {
    logic [DATA_WD-1:0]    pc_plus_4;    // [75:44]
    logic [DATA_WD-1:0]    alu_res;      // [43:12]
    logic [RF_ADDR_WD-1:0] rf_waddr;     // [11:7]
    logic [1:0]            rf_wdata_sel; // [6:5]
    logic                  rf_we;        // [4]
    logic                  is_load;      // [3]
    logic [2:0]            load_type;    // [2:0]
  } exe_to_mem_t;

  // Memory -> write-back payload.
  typedef struct packed {
    logic [DATA_WD-1:0]    pc_plus_4;    // [69:38]
    logic [DATA_WD-1:0]    rf_wdata;     // [37:6]
    logic [RF_ADDR_WD-1:0] rf_waddr;     // [5:1]
    logic                  rf_we;        // [0]
  } mem_to_wb_t;

  // Memory -> bypass network payload.
  typedef struct packed {
    logic [RF_ADDR_WD-1:0] rf_waddr;     // [38:34]
    logic [DATA_WD-1:0]    rf_wdata;     // [33:2]
    logic                  rf_we;        // [1]
    logic                  mem_valid;    // [0]
  } mem_to_by_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational byte/half extraction with sign or zero extension.
//   word      in  32  raw memory word
//   addr_lo   in  2   low address bits selecting byte/half
//   load_type in  3   LT_* encoding
//   data      out 32  aligned, extended load data
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? word[31:16] : word[15:0];
    data   = word;
    case (load_type)
      LT_B:    data = {{24{w_byte[7]}}, w_byte};
      LT_BU:   data = {24'h000000, w_byte};
      LT_H:    data = {{16{w_half[15]}}, w_half};
      LT_HU:   data = {16'h0000, w_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: fourth pipeline stage. Captures the synchronous RAM word on
// the first resident cycle so a stalled load keeps its data, aligns loads,
// selects register write data and drives write-back and bypass buses.
//   clk, reset         clock, synchronous active-high reset
//   exe_to_mem_bus/_valid  upstream payload and valid
//   mem_allow_in       stage can accept this cycle
//   wb_allow_in        downstream can accept
//   mem_to_wb_valid/_bus   downstream valid and payload
//   mem_to_by_bus      bypass payload, bit 0 = stage occupied
//   data_ram_r_data    RAM read word for the address issued last cycle
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
  input  logic                         exe_to_mem_valid,
  output logic                         mem_allow_in,
  input  logic                         wb_allow_in,
  output logic                         mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_BY_BUS_WD-1:0]  mem_to_by_bus,
  input  logic [DATA_WD-1:0]           data_ram_r_data
);

  exe_to_mem_t        r_bus;
  logic               r_mem_valid;
  logic               r_mem_first;
  logic [DATA_WD-1:0] r_rdata_hold;

  logic               w_ready_go;
  logic               w_allow_in;
  logic               w_accept;
  logic [DATA_WD-1:0] w_word;
  logic [DATA_WD-1:0] w_load_data;
  logic [1:0]         w_sel;
  logic [DATA_WD-1:0] w_rf_wdata;
  mem_to_wb_t         w_wb;
  mem_to_by_t         w_by;

  // Handshake: single-cycle stage, always ready to go.
  assign w_ready_go = 1'b1;
  assign w_allow_in = ~r_mem_valid | (w_ready_go & wb_allow_in);
  assign w_accept   = w_allow_in & exe_to_mem_valid;

  // Pipeline register, first-cycle flag and RAM capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_valid  <= 1'b0;
      r_mem_first  <= 1'b0;
      r_bus        <= '0;
      r_rdata_hold <= '0;
    end else begin
      if (w_allow_in) r_mem_valid <= exe_to_mem_valid;
      if (w_accept)   r_bus       <= exe_to_mem_bus;
      r_mem_first <= w_accept;
      if (r_mem_first) r_rdata_hold <= data_ram_r_data;
    end
  end

  // RAM output is only trustworthy on the first resident cycle.
  assign w_word = r_mem_first ? data_ram_r_data : r_rdata_hold;

  load_align u_load_align (
    .word      (w_word),
    .addr_lo   (r_bus.alu_res[1:0]),
    .load_type (r_bus.load_type),
    .data      (w_load_data)
  );

  // Write-data select; loads always take the aligned RAM path.
  always_comb begin
    w_sel      = r_bus.is_load ? SEL_LOAD : r_bus.rf_wdata_sel;
    w_rf_wdata = '0;
    case (w_sel)
      SEL_ALU:  w_rf_wdata = r_bus.alu_res;
      SEL_LINK: w_rf_wdata = r_bus.pc_plus_4 + 32'd4;
      SEL_LOAD: w_rf_wdata = w_load_data;
      SEL_ZERO: w_rf_wdata = '0;
      default:  w_rf_wdata = '0;
    endcase
  end

  always_comb begin
    w_wb.pc_plus_4 = r_bus.pc_plus_4;
    w_wb.rf_wdata  = w_rf_wdata;
    w_wb.rf_waddr  = r_bus.rf_waddr;
    w_wb.rf_we     = r_bus.rf_we;
    w_by.rf_waddr  = r_bus.rf_waddr;
    w_by.rf_wdata  = w_rf_wdata;
    w_by.rf_we     = r_bus.rf_we;
    w_by.mem_valid = r_mem_valid;
  end

  assign mem_allow_in    = w_allow_in;
  assign mem_to_wb_valid = r_mem_valid & w_ready_go;
  assign mem_to_wb_bus   = w_wb;
  assign mem_to_by_bus   = w_by;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-back payloads are
// pushed when an instruction is accepted and compared when offered downstream.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [75:0] exe_to_mem_bus;
  logic        exe_to_mem_valid;
  logic        mem_allow_in;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [38:0] mem_to_by_bus;
  logic [31:0] data_ram_r_data;

  mem_access_stage dut (
    .clk              (clk),
    .reset            (reset),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allow_in     (mem_allow_in),
    .wb_allow_in      (wb_allow_in),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_by_bus    (mem_to_by_bus),
    .data_ram_r_data  (data_ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [69:0] sb_q[$];
  logic        m_valid = 1'b0;
  logic        pend_first = 1'b0;
  logic [31:0] pend_word = '0;
  logic [31:0] junk_word = '0;
  logic        acc = 1'b0;
  int          n_acc = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [4:0] wa, input logic [1:0] sel,
                                         input logic we, input logic ld, input logic [2:0] lt);
    return {pc, alu, wa, sel, we, ld, lt};
  endfunction

  // Reference model of the write-back payload for one instruction and its RAM word.
  function automatic logic [69:0] model_wb(input logic [75:0] b, input logic [31:0] w);
    logic [31:0] pc, alu, ld, wd;
    logic [7:0]  by;
    logic [15:0] h;
    logic [1:0]  sel;
    pc  = b[75:44];
    alu = b[43:12];
    by  = 8'(w >> (32'(alu[1:0]) * 8));
    h   = alu[1] ? w[31:16] : w[15:0];
    case (b[2:0])
      3'd1:    ld = {{24{by[7]}}, by};
      3'd2:    ld = {24'd0, by};
      3'd3:    ld = {{16{h[15]}}, h};
      3'd4:    ld = {16'd0, h};
      default: ld = w;
    endcase
    sel = b[3] ? 2'd2 : b[6:5];
    case (sel)
      2'd0:    wd = alu;
      2'd1:    wd = pc + 32'd4;
      2'd2:    wd = ld;
      default: wd = 32'd0;
    endcase
    return {pc, wd, b[11:7], b[4]};
  endfunction

  // One clock cycle: drive at negedge, compare, advance the model.
  // 'word' is the RAM word delivered next cycle if this instruction is accepted.
  task automatic drive_cycle(input logic v, input logic [75:0] bus,
                             input logic [31:0] word, input logic wb);
    logic [69:0] e;
    logic        allow, drain;
    @(negedge clk);
    data_ram_r_data  = pend_first ? pend_word : junk_word;
    exe_to_mem_valid = v;
    exe_to_mem_bus   = bus;
    wb_allow_in      = wb;
    #1;
    allow = ~m_valid | wb;
    check("allow_in", 70'(mem_allow_in), 70'(allow));
    check("wb_valid", 70'(mem_to_wb_valid), 70'(m_valid));
    check("by_valid", 70'(mem_to_by_bus[0]), 70'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 70'(sb_q.size()), 70'd1);
      end else begin
        e = sb_q[0];
        check("wb_bus", 70'(mem_to_wb_bus), e);
        check("by_bus", 70'(mem_to_by_bus[38:1]), 70'({e[5:1], e[37:6], e[0]}));
      end
    end
    drain = m_valid & wb;
    if (drain && sb_q.size() != 0) void'(sb_q.pop_front());
    acc = allow & v;
    if (allow) m_valid = v;
    if (acc) begin
      sb_q.push_back(model_wb(bus, word));
      n_acc++;
    end
    pend_first = acc;
    pend_word  = word;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    exe_to_mem_valid = 1'b0;
    wb_allow_in      = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_allow_in", 70'(mem_allow_in), 70'd1);
    check("rst_wb_valid", 70'(mem_to_wb_valid), 70'd0);
    check("rst_by_valid", 70'(mem_to_by_bus[0]), 70'd0);
    check("rst_wb_bus", 70'(mem_to_wb_bus), 70'd0);
    m_valid    = 1'b0;
    pend_first = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int cyc;
    reset            = 1'b1;
    exe_to_mem_bus   = '0;
    exe_to_mem_valid = 1'b0;
    wb_allow_in      = 1'b0;
    data_ram_r_data  = '0;
    do_reset();

    // lb from byte 3 of 0x80FF1234 -> sign-extended 0x80
    junk_word = 32'h5555_AAAA;
    drive_cycle(1'b1, mk_bus(32'h100, 32'h1003, 5'd3, 2'd2, 1'b1, 1'b1, 3'd1), 32'h80FF1234, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("lb_valid", 70'(mem_to_wb_valid), 70'd1);
    check("lb_data", 70'(mem_to_wb_bus[37:6]), 70'h0FFFFFF80);

    // lhu upper half, then lh lower half (alu_res[0] ignored)
    drive_cycle(1'b1, mk_bus(32'h104, 32'h2002, 5'd4, 2'd2, 1'b1, 1'b1, 3'd4), 32'hBEEF0011, 1'b1);
    drive_cycle(1'b1, mk_bus(32'h108, 32'h2001, 5'd5, 2'd2, 1'b1, 1'b1, 3'd3), 32'hBEEF0011, 1'b1);
    check("lhu_data", 70'(mem_to_wb_bus[37:6]), 70'h00000BEEF);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("lh_data", 70'(mem_to_wb_bus[37:6]), 70'h000000011);

    // lw held through a 3-cycle stall while RAM output changes
    junk_word = 32'hDEADBEEF;
    drive_cycle(1'b1, mk_bus(32'h10C, 32'h3000, 5'd6, 2'd0, 1'b1, 1'b1, 3'd0), 32'h12345678, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, mk_bus(32'h110, 32'h77, 5'd7, 2'd0, 1'b1, 1'b0, 3'd0), 32'h0, 1'b0);
      check("stall_allow", 70'(mem_allow_in), 70'd0);
      check("stall_data", 70'(mem_to_wb_bus[37:6]), 70'h012345678);
    end
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("release_allow", 70'(mem_allow_in), 70'd1);
    check("release_data", 70'(mem_to_wb_bus[37:6]), 70'h012345678);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("after_release_valid", 70'(mem_to_wb_valid), 70'd0);

    // back-to-back ALU op then jal link value
    drive_cycle(1'b1, mk_bus(32'h200, 32'h5, 5'd8, 2'd0, 1'b1, 1'b0, 3'd0), 32'h0, 1'b1);
    drive_cycle(1'b1, mk_bus(32'h0BFC0008, 32'h9999, 5'd31, 2'd1, 1'b1, 1'b0, 3'd0), 32'h0, 1'b1);
    check("alu_data", 70'(mem_to_wb_bus[37:6]), 70'h000000005);
    check("alu_by0", 70'(mem_to_by_bus[0]), 70'd1);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("jal_data", 70'(mem_to_wb_bus[37:6]), 70'h00BFC000C);
    check("jal_by0", 70'(mem_to_by_bus[0]), 70'd1);

    // r0 write passes through unchanged; rf_wdata_sel=11 gives zero
    drive_cycle(1'b1, mk_bus(32'h300, 32'hABCD, 5'd0, 2'd3, 1'b1, 1'b0, 3'd0), 32'h0, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("r0_waddr_we", 70'(mem_to_wb_bus[5:0]), 70'h01);
    check("zero_sel", 70'(mem_to_wb_bus[37:6]), 70'd0);

    // reset while an instruction is held by a stall
    drive_cycle(1'b1, mk_bus(32'h400, 32'h4000, 5'd9, 2'd0, 1'b1, 1'b1, 3'd0), 32'hCAFE0001, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b0);
    check("pre_reset_valid", 70'(mem_to_wb_valid), 70'd1);
    do_reset();
    drive_cycle(1'b1, mk_bus(32'h500, 32'h42, 5'd10, 2'd0, 1'b1, 1'b0, 3'd0), 32'h0, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1);
    check("post_reset_valid", 70'(mem_to_wb_valid), 70'd1);
    check("post_reset_data", 70'(mem_to_wb_bus[37:6]), 70'h000000042);

    // random stream of 1000 accepted instructions with random back-pressure
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      logic [75:0] b;
      b = mk_bus($urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) == 0), 3'($urandom));
      junk_word = $urandom;
      drive_cycle(($urandom_range(0, 3) != 0), b, $urandom, ($urandom_range(0, 2) != 0));
      cyc++;
    end
    check("random_accepted", 70'(n_acc), 70'd1000);
    cyc = 0;
    while (m_valid && cyc < 50) begin
      drive_cycle(1'b0, '0, '0, 1'b1);
      cyc++;
    end
    check("drain_done", 70'(m_valid), 70'd0);
    check("sb_empty", 70'(sb_q.size()), 70'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
